// File: rtl/three_req_rr_arbiter_pkg.sv
// Shared constants and helpers for the three-requester round-robin arbiter.
// State encodings, requester count and the idle grant index live here.
package three_req_rr_arbiter_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [1:0] IDLE_ID = 2'd3;

  function automatic logic [1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
    case (oh)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return IDLE_ID;
    endcase
  endfunction

endpackage

// File: rtl/three_req_rr_arbiter_rr_pick3.sv
// Combinational round-robin picker: first set request searching last+1, last+2, last (mod 3).
// Returns a one-hot pick and a valid flag.
module rr_pick3
  import three_req_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         last_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  assign valid_o = |req_i;

  always_comb begin
    pick_o = '0;
    case (last_i)
      2'd0: begin
        if      (req_i[1]) pick_o = 3'b010;
        else if (req_i[2]) pick_o = 3'b100;
        else if (req_i[0]) pick_o = 3'b001;
      end
      2'd1: begin
        if      (req_i[2]) pick_o = 3'b100;
        else if (req_i[0]) pick_o = 3'b001;
        else if (req_i[1]) pick_o = 3'b010;
      end
      // last==2 is the reset pointer; the unused code 3 behaves the same way
      default: begin
        if      (req_i[0]) pick_o = 3'b001;
        else if (req_i[1]) pick_o = 3'b010;
        else if (req_i[2]) pick_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/three_req_rr_arbiter.sv
// Round-robin arbiter for three requesters with grant/done handshake and back-to-back regrant.
// Optional forced release after TIMEOUT_CYCLES held cycles under macro ARB_TIMEOUT_EN.
module three_req_rr_arbiter
  import three_req_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               busy,
  output logic               any_req
`ifdef ARB_TIMEOUT_EN
  ,
  output logic               timeout_pulse
`endif
);

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic [1:0]         last_q, last_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick;
  logic [1:0]         pick_id;
  logic               pick_vld;
  logic               owner_req;
  logic               force_rel;
  logic               release_c;

  // Empty marker block that only elaborates when CNT_W cannot count up to TIMEOUT_CYCLES
  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_too_narrow
  end

  assign owner_req = |(req & gnt_q);
  assign release_c = (state_q == GRANT) && (done || !owner_req || force_rel);

  // On release the current owner is masked so a waiting peer always wins
  assign pick_req = (state_q == GRANT) ? (req & ~gnt_q) : req;
  assign pick_id  = onehot_to_id(pick);

  rr_pick3 u_pick (
    .req_i   (pick_req),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    if ((state_q == IDLE) || release_c) begin
      if (pick_vld) begin
        state_d  = GRANT;
        gnt_d    = pick;
        gnt_id_d = pick_id;
        last_d   = pick_id;
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = IDLE_ID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= IDLE_ID;
      last_q   <= 2'd2;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             new_grant;

  assign force_rel = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign new_grant = (state_d == GRANT) && ((state_q == IDLE) || release_c);

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = force_rel && !done && owner_req;
    if (new_grant) begin
      cnt_d = '0;
    end else if ((state_q == GRANT) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_pulse = timeout_q;
`else
  assign force_rel = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q == GRANT);
  assign any_req = |req;

endmodule

// File: tb/tb_three_req_rr_arbiter.sv
// Bench for three_req_rr_arbiter: owner/pointer model checked every cycle plus literal expectations.
module tb_three_req_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       done = 1'b0;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       any_req;
`ifdef ARB_TIMEOUT_EN
  logic       timeout_pulse;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model: owner index (-1 = nobody) and round-robin pointer
  int m_owner = -1;
  int m_last  = 2;

  three_req_rr_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .any_req (any_req)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  always #5 clk = ~clk;

  function automatic int rr_next(input logic [2:0] r, input int last, input int excl);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_owner = -1;
      m_last  = 2;
    end else if (m_owner < 0) begin
      w = rr_next(req, m_last, -1);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
      end
    end else if (done || !req[m_owner]) begin
      w = rr_next(req, m_last, m_owner);
      m_owner = w;
      if (w >= 0) m_last = w;
    end
  end

  task automatic cmp(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] e_gnt;
      logic [1:0] e_id;
      e_gnt = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
      e_id  = (m_owner < 0) ? 2'd3 : 2'(m_owner);
      cmp("cyc_gnt", gnt, e_gnt);
      cmp("cyc_gnt_id", {1'b0, gnt_id}, {1'b0, e_id});
      cmp("cyc_busy", {2'b00, busy}, {2'b00, (m_owner >= 0)});
      cmp("cyc_any_req", {2'b00, any_req}, {2'b00, |req});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  typedef struct { logic [2:0] r; logic d; } vec_t;
  vec_t tbl[12];

  initial begin
    step(2);
    rst = 1'b0;
    chk_en = 1'b1;
    cmp("rst_gnt", gnt, 3'b000);
    cmp("rst_gnt_id", {1'b0, gnt_id}, 3'd3);
    cmp("rst_busy", {2'b00, busy}, 3'd0);

    // rotation 0,1,2,0 with all requesting
    req = 3'b111;
    step();
    cmp("rot_first", gnt, 3'b001);
    pulse_done();
    cmp("rot_second", gnt, 3'b010);
    pulse_done();
    cmp("rot_third", gnt, 3'b100);
    pulse_done();
    cmp("rot_wrap", gnt, 3'b001);
    req = 3'b000;
    step();
    cmp("rot_idle", gnt, 3'b000);

    // single requester, abandon without done
    req = 3'b010;
    step();
    cmp("single_gnt", gnt, 3'b010);
    cmp("single_id", {1'b0, gnt_id}, 3'd1);
    cmp("single_busy", {2'b00, busy}, 3'd1);
    req = 3'b000;
    step();
    cmp("abandon_gnt", gnt, 3'b000);
    cmp("abandon_id", {1'b0, gnt_id}, 3'd3);
    cmp("abandon_busy", {2'b00, busy}, 3'd0);

    // no preemption mid-grant, then direct handover
    req = 3'b100;
    step();
    cmp("hold_start", gnt, 3'b100);
    req = 3'b101;
    step(3);
    cmp("hold_no_preempt", gnt, 3'b100);
    pulse_done();
    cmp("handover", gnt, 3'b001);
    req = 3'b000;
    step();

    // done in idle ignored
    done = 1'b1;
    step(2);
    done = 1'b0;
    cmp("idle_done_gnt", gnt, 3'b000);
    cmp("idle_done_id", {1'b0, gnt_id}, 3'd3);

    // done and request drop together: one release only
    req = 3'b011;
    step();
    cmp("dual_rel_pre", gnt, 3'b010);
    req = 3'b001;
    pulse_done();
    cmp("dual_rel_once", gnt, 3'b001);
    step();
    cmp("dual_rel_stable", gnt, 3'b001);
    req = 3'b000;
    step();

    // reset mid-grant restores the pointer
    req = 3'b010;
    step();
    cmp("rst_mid_pre", gnt, 3'b010);
    rst = 1'b1;
    step();
    cmp("rst_mid_gnt", gnt, 3'b000);
    rst = 1'b0;
    req = 3'b111;
    step();
    cmp("rst_ptr", gnt, 3'b001);
    req = 3'b000;
    step();

    // no timeout in the default build
    req = 3'b110;
    step(20);
    cmp("no_timeout", gnt, 3'b010);
    req = 3'b000;
    step();

    // mixed traffic checked by the per-cycle model
    tbl[0]  = '{3'b101, 1'b0}; tbl[1]  = '{3'b101, 1'b1};
    tbl[2]  = '{3'b111, 1'b0}; tbl[3]  = '{3'b011, 1'b1};
    tbl[4]  = '{3'b010, 1'b0}; tbl[5]  = '{3'b110, 1'b1};
    tbl[6]  = '{3'b100, 1'b1}; tbl[7]  = '{3'b000, 1'b0};
    tbl[8]  = '{3'b001, 1'b1}; tbl[9]  = '{3'b011, 1'b0};
    tbl[10] = '{3'b110, 1'b1}; tbl[11] = '{3'b000, 1'b1};
    for (int i = 0; i < 12; i++) begin
      req  = tbl[i].r;
      done = tbl[i].d;
      step();
    end
    done = 1'b0;
    req  = 3'b000;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
